// File: rtl/sram_icb_pkg.sv
// Shared ICB command payload and default widths for the SRAM arbiter slice.
package sram_icb_pkg;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_ADDR_W = 19;
  localparam int unsigned DEF_MW     = DEF_WIDTH / 8;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic                  read;
    logic [DEF_WIDTH-1:0]  wdata;
    logic [DEF_MW-1:0]     wmask;
  } icb_cmd_t;

endpackage

// File: rtl/icb_id_fifo.sv
// Small synchronous FIFO holding requester IDs of issued commands, in issue order.
module icb_id_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int unsigned PW = $clog2(DEPTH) + 1;
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [IW-1:0] wr_idx, rd_idx;

  // Extra pointer bit distinguishes full from empty when the low bits match.
  always_comb begin
    wr_idx   = IW'(wr_ptr_q % PW'(DEPTH));
    rd_idx   = IW'(rd_ptr_q % PW'(DEPTH));
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (PW'(wr_ptr_q - rd_ptr_q) == PW'(DEPTH));
    head     = mem_q[rd_idx];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop && !empty) rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_idx] <= din;
  end

endmodule

// File: rtl/sram_icb_rr_arbiter.sv
// Round-robin arbiter sharing one ICB slave among N requesters; issue order is
// tracked in an ID FIFO so in-order responses route back to their issuer.
module sram_icb_rr_arbiter
  import sram_icb_pkg::*;
#(
  parameter int unsigned N      = 2,
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned MW     = DEF_MW,
  parameter int unsigned OUTS   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        s_cmd_valid,
  output logic [N-1:0]        s_cmd_ready,
  input  logic [N*ADDR_W-1:0] s_cmd_addr,
  input  logic [N-1:0]        s_cmd_read,
  input  logic [N*WIDTH-1:0]  s_cmd_wdata,
  input  logic [N*MW-1:0]     s_cmd_wmask,
  output logic [N-1:0]        s_rsp_valid,
  input  logic [N-1:0]        s_rsp_ready,
  output logic [WIDTH-1:0]    s_rsp_rdata,
  output logic                s_rsp_err,
  output logic                m_cmd_valid,
  input  logic                m_cmd_ready,
  output logic [ADDR_W-1:0]   m_cmd_addr,
  output logic                m_cmd_read,
  output logic [WIDTH-1:0]    m_cmd_wdata,
  output logic [MW-1:0]       m_cmd_wmask,
  input  logic                m_rsp_valid,
  output logic                m_rsp_ready,
  input  logic [WIDTH-1:0]    m_rsp_rdata,
  input  logic                m_rsp_err,
  output logic                busy,
  output logic                unexp_rsp
);

  localparam int unsigned ID_W = (N > 1) ? $clog2(N) : 1;

  logic [ID_W-1:0] ptr_q, ptr_d, lock_id_q, lock_id_d;
  logic [ID_W-1:0] cand, grant, head;
  logic            lock_q, lock_d, unexp_q, unexp_d;
  logic            fifo_full, fifo_empty, cmd_valid, cmd_hs, rsp_pop;

  // First valid requester at or after the pointer, wrapping mod N.
  always_comb begin : rr_select
    logic [ID_W-1:0] idx;
    logic            found;
    idx   = '0;
    found = 1'b0;
    cand  = ptr_q;
    for (int unsigned k = 0; k < N; k++) begin
      idx = ID_W'((32'(ptr_q) + k) % N);
      if (!found && s_cmd_valid[idx]) begin
        found = 1'b1;
        cand  = idx;
      end
    end
  end

  // A stalled grant stays locked until its handshake so the command is stable.
  always_comb begin
    grant     = lock_q ? lock_id_q : cand;
    cmd_valid = (|s_cmd_valid) & !fifo_full;
    cmd_hs    = cmd_valid & m_cmd_ready;
    rsp_pop   = m_rsp_valid & !fifo_empty & s_rsp_ready[head];
    ptr_d     = ptr_q;
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    unexp_d   = unexp_q | (m_rsp_valid & fifo_empty);
    if (cmd_hs) begin
      ptr_d  = ID_W'((32'(grant) + 1) % N);
      lock_d = 1'b0;
    end else if (cmd_valid) begin
      lock_d    = 1'b1;
      lock_id_d = grant;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      unexp_q   <= 1'b0;
    end else begin
      ptr_q     <= ptr_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      unexp_q   <= unexp_d;
    end
  end

  icb_id_fifo #(
    .DEPTH (OUTS),
    .W     (ID_W)
  ) u_id_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_hs),
    .pop   (rsp_pop),
    .din   (grant),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  // Combinational outputs are held at zero while reset is asserted.
  always_comb begin
    s_cmd_ready = '0;
    s_rsp_valid = '0;
    s_rsp_rdata = '0;
    s_rsp_err   = 1'b0;
    m_cmd_valid = 1'b0;
    m_cmd_addr  = '0;
    m_cmd_read  = 1'b0;
    m_cmd_wdata = '0;
    m_cmd_wmask = '0;
    m_rsp_ready = 1'b0;
    busy        = 1'b0;
    if (rst_n) begin
      s_cmd_ready[grant] = m_cmd_ready & !fifo_full;
      s_rsp_valid[head]  = m_rsp_valid & !fifo_empty;
      s_rsp_rdata        = m_rsp_rdata;
      s_rsp_err          = m_rsp_err;
      m_cmd_valid        = cmd_valid;
      m_cmd_addr         = s_cmd_addr[32'(grant)*ADDR_W +: ADDR_W];
      m_cmd_read         = s_cmd_read[grant];
      m_cmd_wdata        = s_cmd_wdata[32'(grant)*WIDTH +: WIDTH];
      m_cmd_wmask        = s_cmd_wmask[32'(grant)*MW +: MW];
      m_rsp_ready        = fifo_empty ? 1'b1 : s_rsp_ready[head];
      busy               = !fifo_empty | cmd_valid;
    end
  end

  assign unexp_rsp = unexp_q;

endmodule
